// File: rtl/cpu_boot_sequencer.sv
// cpu_boot_sequencer: streams a program from the host into the CPU
// instruction memory, holds the CPU in reset while loading and for a short
// settle time, then runs it for a bounded or unbounded number of cycles.
module cpu_boot_sequencer #(
  parameter logic [31:0] ADDR_BASE = 32'd0,
  parameter int          MAX_WORDS = 64,
  parameter int          RST_HOLD  = 4,
  parameter int          CNT_W     = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           prog_valid,
  output logic                           prog_ready,
  input  logic [31:0]                    prog_data,
  input  logic                           prog_last,
  input  logic [CNT_W-1:0]               run_cycles,
  input  logic                           abort,
  output logic                           cpu_rst,
  output logic                           initialize,
  output logic [31:0]                    init_addr,
  output logic [31:0]                    init_data,
  output logic                           running,
  output logic                           done,
  output logic                           error,
  output logic [$clog2(MAX_WORDS+1)-1:0] word_count
);

  localparam int WC_W = $clog2(MAX_WORDS+1);
  localparam int HC_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [31:0]       addr;       // address the next loaded word goes to
  logic [HC_W-1:0]   hold_cnt;
  logic [CNT_W-1:0]  run_cnt;
  logic [CNT_W-1:0]  run_len;    // run length latched with the last word

  logic              accept, start, full, wr, ovf, hold_end, run_end;
  logic [WC_W-1:0]   cnt_eff;
  logic [31:0]       wr_addr;

  // Handshake decode and next-state selection. A new load from IDLE/DONE
  // behaves as if the word count and address were already rewound.
  always_comb begin
    state_nxt  = state;
    prog_ready = ((state == S_IDLE) || (state == S_LOAD) || (state == S_DONE)) && !abort;
    accept     = prog_valid && prog_ready;
    start      = accept && (state != S_LOAD);
    cnt_eff    = start ? '0 : word_count;
    wr_addr    = start ? ADDR_BASE : addr;
    full       = (cnt_eff == WC_W'(MAX_WORDS));
    wr         = accept && !full;
    ovf        = accept && full;
    hold_end   = (state == S_HOLD) && (hold_cnt == HC_W'(RST_HOLD-1));
    run_end    = (state == S_RUN) && (run_len != '0) && (run_cnt == run_len - CNT_W'(1));
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_LOAD, S_DONE: begin
          if (ovf)     state_nxt = S_DONE;
          else if (wr) state_nxt = prog_last ? S_HOLD : S_LOAD;
        end
        S_HOLD:  if (hold_end) state_nxt = S_RUN;
        S_RUN:   if (run_end)  state_nxt = S_DONE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Registered outputs, load datapath and the hold/run counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_rst    <= 1'b1;
      initialize <= 1'b0;
      init_addr  <= ADDR_BASE;
      init_data  <= '0;
      running    <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
      addr       <= ADDR_BASE;
      hold_cnt   <= '0;
      run_cnt    <= '0;
      run_len    <= '0;
    end else begin
      cpu_rst    <= (state_nxt != S_RUN);
      running    <= (state_nxt == S_RUN);
      // done only survives while we stay in DONE, so a new load or abort drops it
      done       <= (state_nxt == S_DONE) && (done || run_end);
      initialize <= wr;
      hold_cnt   <= ((state == S_HOLD) && !hold_end) ? hold_cnt + HC_W'(1) : '0;
      run_cnt    <= (state == S_RUN) ? run_cnt + CNT_W'(1) : '0;
      if (start) begin
        word_count <= '0;
        error      <= 1'b0;
      end
      if (ovf) error <= 1'b1;
      if (wr) begin
        init_addr  <= wr_addr;
        init_data  <= prog_data;
        addr       <= wr_addr + 32'd4;
        word_count <= cnt_eff + WC_W'(1);
        if (prog_last) run_len <= run_cycles;
      end
    end
  end

endmodule

// File: tb/tb_cpu_boot_sequencer.sv
// Bench for cpu_boot_sequencer: a timeline model (phase derived from the
// edge of the last accepted word) checked every cycle, plus literal checks.
module tb_cpu_boot_sequencer;

  localparam int          MAXW = 4;
  localparam int          HOLD = 4;
  localparam int          CW   = 16;
  localparam logic [31:0] BASE = 32'h0;

  localparam int P_IDLE = 0, P_LOAD = 1, P_HOLD = 2, P_RUN = 3, P_DONE = 4, P_OVF = 5;

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         prog_valid, prog_ready, prog_last, abort;
  logic [31:0]                  prog_data;
  logic [CW-1:0]                run_cycles;
  logic                         cpu_rst, initialize, running, done, error;
  logic [31:0]                  init_addr, init_data;
  logic [$clog2(MAXW+1)-1:0]    word_count;

  cpu_boot_sequencer #(.ADDR_BASE(BASE), .MAX_WORDS(MAXW), .RST_HOLD(HOLD), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .prog_valid(prog_valid), .prog_ready(prog_ready),
    .prog_data(prog_data), .prog_last(prog_last), .run_cycles(run_cycles),
    .abort(abort), .cpu_rst(cpu_rst), .initialize(initialize),
    .init_addr(init_addr), .init_data(init_data), .running(running),
    .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: a loaded program is described by the edge it finished on and
  // its run length; everything else is arithmetic on the cycle number.
  int          cyc = 0;
  bit          has_prog = 0, in_load = 0, ovf_stop = 0, err = 0;
  int          wc = 0, k_last = 0, r_len = 0;
  bit          m_init = 0;
  logic [31:0] m_addr = BASE, m_data = 0;

  function automatic int phase();
    int d;
    if (has_prog) begin
      d = cyc - k_last;
      if (d <= HOLD)                           return P_HOLD;
      else if (r_len == 0 || d <= HOLD + r_len) return P_RUN;
      else                                      return P_DONE;
    end
    if (in_load)  return P_LOAD;
    if (ovf_stop) return P_OVF;
    return P_IDLE;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      has_prog = 0; in_load = 0; ovf_stop = 0; err = 0; wc = 0;
      m_init = 0; m_addr = BASE; m_data = 0;
    end else begin
      int ph;
      ph = phase();
      m_init = 0;
      if (abort) begin
        has_prog = 0; in_load = 0; ovf_stop = 0;
      end else if (prog_valid && ph != P_HOLD && ph != P_RUN) begin
        if (ph != P_LOAD) begin
          wc = 0; err = 0; has_prog = 0; ovf_stop = 0; in_load = 1;
        end
        if (wc == MAXW) begin
          err = 1; ovf_stop = 1; in_load = 0;
        end else begin
          m_init = 1;
          m_addr = BASE + 32'(4 * wc);
          m_data = prog_data;
          wc++;
          if (prog_last) begin
            has_prog = 1; in_load = 0; k_last = cyc; r_len = int'(run_cycles);
          end
        end
      end
      cyc++;
    end
  end

  logic [31:0] seen_addr[$];
  int          low_cnt = 0;

  // Every-cycle comparison against the model, on the falling edge.
  initial forever begin
    int ph;
    @(negedge clk);
    ph = phase();
    chk("prog_ready", prog_ready, (ph != P_HOLD && ph != P_RUN) && !abort);
    chk("cpu_rst", cpu_rst, ph != P_RUN);
    chk("running", running, ph == P_RUN);
    chk("done", done, ph == P_DONE);
    chk("error", error, err);
    chk("word_count", word_count, wc);
    chk("initialize", initialize, m_init);
    chk("init_addr", init_addr, m_addr);
    chk("init_data", init_data, m_data);
    if (initialize) seen_addr.push_back(init_addr);
    if (!cpu_rst) low_cnt++;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic last, input logic [CW-1:0] rc);
    prog_valid = 1'b1; prog_data = d; prog_last = last; run_cycles = rc;
    tick();
    prog_valid = 1'b0; prog_last = 1'b0;
  endtask

  initial begin
    rst = 1'b0; prog_valid = 1'b0; prog_data = '0; prog_last = 1'b0;
    run_cycles = '0; abort = 1'b0;
    tick(2);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_init_addr", init_addr, BASE);
    chk("rst_word_count", word_count, 0);
    rst = 1'b1;
    tick();

    // three words back to back, run 5
    seen_addr.delete(); low_cnt = 0;
    send(32'h1111_0001, 0, 0); send(32'h2222_0002, 0, 0); send(32'h3333_0003, 1, 5);
    tick(14);
    chk("t1_writes", seen_addr.size(), 3);
    chk("t1_addr0", seen_addr[0], 32'd0);
    chk("t1_addr1", seen_addr[1], 32'd4);
    chk("t1_addr2", seen_addr[2], 32'd8);
    chk("t1_low_cycles", low_cnt, 5);
    chk("t1_done", done, 1);
    chk("t1_word_count", word_count, 3);

    // host stalls of 3 cycles between words, run 2
    seen_addr.delete(); low_cnt = 0;
    send(32'hAAAA_0001, 0, 0); tick(3);
    send(32'hAAAA_0002, 0, 0); tick(3);
    send(32'hAAAA_0003, 1, 2);
    tick(10);
    chk("t2_writes", seen_addr.size(), 3);
    chk("t2_addr2", seen_addr[2], 32'd8);
    chk("t2_low_cycles", low_cnt, 2);
    chk("t2_done", done, 1);

    // overflow: five words, no last
    seen_addr.delete();
    for (int i = 0; i < 5; i++) send(32'hB000_0000 + 32'(i), 0, 0);
    tick(2);
    chk("t3_writes", seen_addr.size(), 4);
    chk("t3_error", error, 1);
    chk("t3_done", done, 0);
    chk("t3_cpu_rst", cpu_rst, 1);
    chk("t3_word_count", word_count, 4);

    // reload from DONE after overflow
    send(32'hC000_0001, 0, 0);
    chk("t4_error_clr", error, 0);
    chk("t4_addr", init_addr, BASE);
    send(32'hC000_0002, 1, 3);
    tick(10);
    chk("t4_word_count", word_count, 2);
    chk("t4_done", done, 1);

    // abort with a word offered: not accepted, done dropped
    prog_valid = 1'b1; prog_data = 32'hDEAD_BEEF; prog_last = 1'b1; abort = 1'b1;
    #1;
    chk("t5_abort_ready", prog_ready, 0);
    tick();
    abort = 1'b0; prog_valid = 1'b0; prog_last = 1'b0;
    chk("t5_abort_done", done, 0);
    chk("t5_abort_init", initialize, 0);

    // unbounded run, then abort
    send(32'hD000_0001, 1, 0);
    tick(HOLD + 1100);
    chk("t5_running", running, 1);
    abort = 1'b1;
    #1;
    chk("t5_ready_abort", prog_ready, 0);
    tick();
    abort = 1'b0;
    chk("t5_run_stop", running, 0);
    chk("t5_cpu_rst", cpu_rst, 1);

    // reset in the middle of a load
    send(32'hE000_0001, 0, 0); send(32'hE000_0002, 0, 0);
    #1 rst = 1'b0;
    #1;
    chk("t6_rst_init", initialize, 0);
    chk("t6_rst_wc", word_count, 0);
    chk("t6_rst_addr", init_addr, BASE);
    tick();
    rst = 1'b1;
    tick();
    send(32'hF000_0001, 1, 3);
    chk("t6_reload_addr", init_addr, BASE);
    chk("t6_reload_init", initialize, 1);
    tick(HOLD);
    chk("t6_running", running, 1);
    // reset in the middle of the run
    #1 rst = 1'b0;
    #1;
    chk("t6_rst_running", running, 0);
    chk("t6_rst_cpu_rst", cpu_rst, 1);
    tick();
    rst = 1'b1;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_boot_sequencer.md
# cpu_boot_sequencer

Boot and run controller for the single-cycle CPU. Accepts a program from a host over a valid/ready stream and writes it into the CPU instruction memory through the CPU's `initialize` / `instruction_initialize_address` / `instruction_initialize_data` ports. Holds the CPU in reset while loading and for a programmable settle time. Then releases it for a bounded or unbounded number of cycles and reports completion. Sits between the testbench/host loader and the `cpu` top.

## Interface
Parameters:
- `ADDR_BASE`, default 0: byte address of the first program word.
- `MAX_WORDS`, default 64: program capacity in words.
- `RST_HOLD`, default 4, minimum 1: cycles the CPU reset stays asserted after the last word is accepted.
- `CNT_W`, default 16: width of `run_cycles` and the run counter.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `prog_valid`, in, 1: host word valid.
- `prog_ready`, out, 1: sequencer can accept a word.
- `prog_data`, in, 32: instruction word.
- `prog_last`, in, 1: marks the final word; qualified by the handshake.
- `run_cycles`, in, `CNT_W`: run length, sampled with the last word. 0 = run until abort.
- `abort`, in, 1: stop immediately and return to IDLE.
- `cpu_rst`, out, 1: drives `cpu.rst`, active-high.
- `initialize`, out, 1: drives `cpu.initialize`.
- `init_addr`, out, 32: drives `cpu.instruction_initialize_address`.
- `init_data`, out, 32: drives `cpu.instruction_initialize_data`.
- `running`, out, 1: high while in RUN.
- `done`, out, 1: high in DONE after a run ends normally.
- `error`, out, 1: sticky; set on capacity overflow.
- `word_count`, out, `$clog2(MAX_WORDS+1)`: number of words written in the current load.

## Operation
- **States:** IDLE, LOAD, HOLD, RUN, DONE.
- **Handshake:**
  - `prog_ready` = (state is IDLE, LOAD or DONE) and not `abort`. It is combinational from state and `abort`.
  - A word is accepted on a rising edge where `prog_valid & prog_ready`.
- **Starting a load:** an accept in IDLE or DONE starts a new load.
  - Clears `word_count`, `error` and `done`.
  - Sets the write address to `ADDR_BASE`.
  - Writes the word, and goes to LOAD, or to HOLD if `prog_last` is set.
- **Word write:**
  - An accepted word with `word_count < MAX_WORDS` registers `init_data` = `prog_data` and `init_addr` = current address.
  - `initialize` is high for exactly the following cycle.
  - The address then advances by 4 and `word_count` increments.
- **Overflow:** an accept with `word_count == MAX_WORDS` does not write.
  - `initialize` stays low and `error` is set.
  - State goes to DONE with `done` = 0. `prog_last` is ignored.
- **Last word:** an accept with `prog_last` = 1 (no overflow) writes the word, latches `run_cycles`, clears the hold counter and moves to HOLD.
- **HOLD:** `cpu_rst` stays 1. After `RST_HOLD` cycles, move to RUN.
- **RUN:** `cpu_rst` = 0 and `running` = 1.
  - The run counter increments every cycle.
  - If latched `run_cycles` ≠ 0 and the counter equals `run_cycles` − 1 at an edge, move to DONE: `done` = 1, `cpu_rst` = 1.
- **DONE:** `cpu_rst` = 1. Waits for a new program word; a repeated run needs a reload.
- **Abort:** `abort` in any state moves to IDLE on the next edge.
  - `cpu_rst` = 1 and `initialize` = 0 on that edge.
  - `done` is cleared; `error` is preserved.
  - An accept is impossible in the same cycle as `abort`.
- **CPU reset rule:** `cpu_rst` = 1 in every state except RUN.

## Timing
- **Reset values:** state IDLE, `cpu_rst` = 1, `initialize` = 0, `init_addr` = `ADDR_BASE`, `init_data` = 0, `running` = 0, `done` = 0, `error` = 0, `word_count` = 0, all counters 0.
- **Outputs:** all registered except `prog_ready`.
- **Write latency:**
  - Word accepted at edge k gives `initialize` / `init_addr` / `init_data` valid during cycle k+1.
  - The memory captures the word at edge k+1.
  - Back-to-back accepts give one write per cycle.
- **Last word accepted at edge k:**
  - HOLD occupies cycles k+1 … k+`RST_HOLD`.
  - `cpu_rst` falls after edge k+`RST_HOLD`.
  - Exactly `run_cycles` cycles follow with `cpu_rst` = 0; `done` rises on the edge ending the last one.
- **Reset during operation:** asserting `rst` mid-load or mid-run returns every output to its reset value asynchronously. Memory contents are not cleared.
- **Address:** wraps modulo 2^32. This is unreachable for `MAX_WORDS` ≤ 2^30.

## Test plan
- **Three-word load, `run_cycles` = 5, `RST_HOLD` = 4:**
  - `init_addr` shows 0, 4, 8 on three consecutive cycles with `initialize` high.
  - `cpu_rst` low for exactly 5 cycles starting 4 cycles after the last accept.
  - Then `done` = 1 and `word_count` = 3.
- **Host stall (`prog_valid` gaps of 3 cycles between words):** `initialize` pulses once per word only; addresses are contiguous.
- **Overflow (`MAX_WORDS` = 4, 5 words sent, no `prog_last`):**
  - 4 writes, 5th not written.
  - `error` = 1, state DONE, `done` = 0, `cpu_rst` = 1.
- **`run_cycles` = 0:**
  - `running` stays high for 1000+ cycles.
  - `abort` gives `cpu_rst` = 1 and `running` = 0 on the next edge, and `prog_ready` = 0 in the `abort` cycle.
- **Reload from DONE:** a new 2-word program restarts at `ADDR_BASE`, clears `done` and `error`, and `word_count` returns to 2.
- **`rst` pulled low in the middle of a load (after 2 words) and mid-run:** outputs take reset values immediately. The next load starts at `ADDR_BASE`.
